// File: rtl/booth_mul_pkg.sv
// Shared types and constants for the radix-4 Booth sequential multiplier.
// Widths here describe the default 64-bit build; the sequencer derives its own from XLEN.
package booth_mul_pkg;

    localparam int XLEN_DEF = 64;
    localparam int ITERS    = XLEN_DEF / 2 + 1;
    localparam int ACC_W    = 2 * XLEN_DEF + 2;
    localparam int MPLR_W   = XLEN_DEF + 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        PP_ZERO = 3'd0,
        PP_POS1 = 3'd1,
        PP_POS2 = 3'd2,
        PP_NEG1 = 3'd3,
        PP_NEG2 = 3'd4
    } pp_sel_t;

    localparam logic [2:0] SL_POS2 = 3'b011;
    localparam logic [2:0] SL_NEG2 = 3'b100;

    function automatic pp_sel_t booth_decode(input logic [2:0] slice);
        case (slice)
            3'b001, 3'b010: return PP_POS1;
            SL_POS2:        return PP_POS2;
            SL_NEG2:        return PP_NEG2;
            3'b101, 3'b110: return PP_NEG1;
            default:        return PP_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational radix-4 Booth partial-product generator: one 3-bit slice
// selects 0, +/-M or +/-2M of the multiplicand, all modulo 2^W.
module booth_pp_gen
    import booth_mul_pkg::*;
#(
    parameter int W = ACC_W
) (
    input  logic [2:0]          slice,
    input  logic signed [W-1:0] mcand,
    output logic signed [W-1:0] pp
);

    always_comb begin
        pp = '0;
        case (booth_decode(slice))
            PP_POS1: pp = mcand;
            PP_POS2: pp = mcand <<< 1;
            PP_NEG1: pp = -mcand;
            PP_NEG2: pp = -(mcand <<< 1);
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier: one slice per cycle into a shared accumulator.
// Optional BOOTH_MUL_EARLY_TERM_EN finishes once the remaining multiplier is all 0s or all 1s.
module booth_mul_seq
    import booth_mul_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   op1,
    input  logic [XLEN-1:0]   op2,
    input  logic              op_signed,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*XLEN-1:0] result,
    output logic              busy
);

    localparam int NIT = XLEN / 2 + 1;
    localparam int AW  = 2 * XLEN + 2;
    localparam int MW  = XLEN + 3;
    localparam int CW  = $clog2(NIT + 1);

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt;
    logic signed [AW-1:0]  mcand;
    logic signed [MW-1:0]  mplr;
    logic signed [AW-1:0]  acc;
    logic signed [AW-1:0]  pp;
    logic signed [AW-1:0]  acc_sum;
    logic [2*XLEN-1:0]     result_q;
    logic                  accept;
    logic                  last;
    logic                  term;
    logic                  sgn1, sgn2;

    booth_pp_gen #(.W(AW)) u_pp_gen (
        .slice (mplr[2:0]),
        .mcand (mcand),
        .pp    (pp)
    );

    assign acc_sum = acc + pp;
    assign last    = (cnt == CW'(NIT - 1));
    assign accept  = in_valid & in_ready & ~flush;
    assign sgn1    = op_signed & op1[XLEN-1];
    assign sgn2    = op_signed & op2[XLEN-1];

`ifdef BOOTH_MUL_EARLY_TERM_EN
    // Uniform remaining multiplier bits mean every further slice encodes zero.
    assign term = (&mplr) | ~(|mplr);
`else
    assign term = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)       state_nxt = BUSY;
            BUSY:    if (term || last)   state_nxt = DONE;
            DONE:    if (out_ready)      state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == BUSY) || (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            mcand    <= '0;
            mplr     <= '0;
            acc      <= '0;
            result_q <= '0;
        end else if (accept) begin
            cnt   <= '0;
            acc   <= '0;
            mcand <= {{(AW - XLEN){sgn1}}, op1};
            mplr  <= {{2{sgn2}}, op2, 1'b0};
        end else if (state == BUSY && !flush) begin
            if (term) begin
                result_q <= acc[2*XLEN-1:0];
            end else begin
                acc   <= acc_sum;
                mcand <= mcand <<< 2;
                mplr  <= mplr >>> 2;
                cnt   <= cnt + CW'(1);
                if (last) result_q <= acc_sum[2*XLEN-1:0];
            end
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq with a result/latency scoreboard.
// Latency expectations follow BOOTH_MUL_EARLY_TERM_EN when it is defined.
module tb_booth_mul_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  op1;
    logic [63:0]  op2;
    logic         op_signed;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] result;
    logic         busy;

    typedef struct {
        logic [127:0] res;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

`ifdef BOOTH_MUL_EARLY_TERM_EN
    localparam bit ET_EN = 1'b1;
`else
    localparam bit ET_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    booth_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .op_signed (op_signed),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                             input logic s);
        logic [127:0] ea, eb;
        ea = s ? {{64{a[63]}}, a} : {64'd0, a};
        eb = s ? {{64{b[63]}}, b} : {64'd0, b};
        return ea * eb;
    endfunction

    // Edges from the accept edge to the first cycle with out_valid high.
    function automatic int ref_lat(input logic [63:0] b, input logic s);
        logic [66:0] m;
        int          n;
        m = {{2{s & b[63]}}, b, 1'b0};
        n = 33;
        for (int k = 0; k < 33; k++) begin
            if ((&m) || ~(|m)) begin
                n = k + 1;
                break;
            end
            m = {{2{m[66]}}, m[66:2]};
        end
        return ET_EN ? n : 33;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic s,
                         input bit keep);
        int   guard;
        exp_t e;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("issue_in_ready", in_ready, 1);
        op1       = a;
        op2       = b;
        op_signed = s;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (keep) begin
            e.res = ref_mul(a, b, s);
            e.lat = ref_lat(b, s);
            sb.push_back(e);
        end
    endtask

    task automatic collect(output logic [127:0] exp_res);
        int   n;
        exp_t e;
        n     = 0;
        e.res = '0;
        e.lat = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("out_valid_seen", out_valid, 1);
        check("sb_depth", sb.size(), 1);
        if (sb.size() > 0) e = sb.pop_front();
        check("result", result, e.res);
        check("latency", n, e.lat);
        check("in_ready_in_done", in_ready, 0);
        check("busy_in_done", busy, 1);
        exp_res = e.res;
        if (out_ready) begin
            @(posedge clk); #1;
            check("out_valid_drop", out_valid, 0);
            check("in_ready_back", in_ready, 1);
        end
    endtask

    task automatic quiet(input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("no_out_valid", seen, 0);
        check("idle_not_busy", busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] er;
        logic [63:0]  a, b;
        logic         s;

        rst       = 1'b1;
        in_valid  = 1'b0;
        op1       = '0;
        op2       = '0;
        op_signed = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        issue(64'd3, 64'd5, 1'b0, 1'b1);
        collect(er);
        check("u3x5_value", er, 128'd15);

        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        collect(er);
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        collect(er);
        issue(64'h8000_0000_0000_0000, 64'd2, 1'b1, 1'b1);
        collect(er);
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1, 1'b1);
        collect(er);
        issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        collect(er);

        for (int i = 0; i < 10; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            s = i[0];
            issue(a, b, s, 1'b1);
            collect(er);
        end

        // Backpressure: result held, new request ignored.
        out_ready = 1'b0;
        issue(64'hDEAD_BEEF_0123_4567, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b1);
        collect(er);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin
                op1       = 64'd9;
                op2       = 64'd9;
                op_signed = 1'b0;
                in_valid  = 1'b1;
            end
            @(posedge clk); #1;
            check("bp_result_stable", result, er);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        quiet(40);

        // Flush during iteration 10.
        issue(64'd123456789, 64'd987654321, 1'b0, 1'b0);
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        check("flush_busy", busy, 0);
        quiet(40);

        // Asynchronous reset during iteration 20.
        issue(64'd55555, 64'd77777, 1'b0, 1'b0);
        repeat (20) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("arst_in_ready", in_ready, 1);
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_result", result, 0);
        #1;
        rst = 1'b0;
        quiet(40);

        issue(64'd7, 64'd6, 1'b0, 1'b1);
        collect(er);
        check("u7x6_value", er, 128'd42);

`ifdef BOOTH_MUL_EARLY_TERM_EN
        issue(64'h1234_5678_9ABC_DEF0, 64'd0, 1'b0, 1'b1);
        collect(er);
        issue(64'h1234_5678_9ABC_DEF0, 64'd1, 1'b0, 1'b1);
        collect(er);
        issue(64'h0000_0000_0000_0BAD, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        collect(er);
        check("et_neg_op1", er, -128'sd2989);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_mul_seq.md
# booth_mul_seq

Iterative radix-4 Booth multiplier sequencer: accepts one 64x64 multiply over a valid/ready handshake and produces the 128-bit product after a fixed number of cycles. It evaluates one Booth slice per cycle through a single shared partial-product generator and a 130-bit accumulator. It sits between the issue stage and writeback as the multi-cycle alternative to the array multiplier, trading area for latency.

## Interface
- `XLEN`, 64: operand width. Slice count `ITERS = XLEN/2 + 1` (33).
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `op1`  in  XLEN  multiplicand.
- `op2`  in  XLEN  multiplier.
- `op_signed`  in  1  1: both operands two's complement; 0: both unsigned.
- `flush`  in  1  abort the current operation.
- `out_valid`  out  1  result valid; high only in DONE.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  2*XLEN  product, low 128 bits of the accumulator.
- `busy`  out  1  high in BUSY or DONE.

## Operation
- FSM: IDLE -> BUSY on `in_valid & in_ready`; BUSY -> DONE after the last iteration; DONE -> IDLE on `out_ready`.
- Capture at accept: multiplicand sign-extended (`op_signed`=1) or zero-extended to 130 bits; multiplier extended the same way to 66 bits, with an implicit 0 appended below bit 0 (67-bit register). Accumulator cleared, counter `cnt`=0.
- Iteration `i` (BUSY): slice = multiplier-register bits [2:0]. Encoding: 000/111 -> 0, 001/010 -> +M, 011 -> +2M, 100 -> -2M, 101/110 -> -M. Negation is two's complement mod 2^130. Acc += pp. Multiplicand register shifts left by 2, multiplier register shifts right by 2 (arithmetic), `cnt`++.
- The last iteration is `cnt`==ITERS-1. `result` = acc[127:0] and is held stable while `out_valid` is high.
- `flush` has priority over every transition. In any state it returns the FSM to IDLE next cycle and drops the result. `out_valid` must not assert for a flushed op.
- `in_valid` while not IDLE is ignored (no queueing). `in_ready` and `out_valid` are never high together.
- Reset, including mid-operation: state=IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `result`=0, `cnt`=0, acc=0.

## Timing
- Accept at cycle T. Iteration i executes at T+1+i. DONE and `out_valid` at T+34. Earliest next accept at T+35 if `out_ready` is high at T+34.
- `result` is registered and changes only on the DONE entry edge.
- `out_ready` low: DONE held indefinitely, `result` unchanged.
- `flush` and `out_ready` in the same DONE cycle: flush wins and the result counts as not delivered.

## Configuration
- `BOOTH_MUL_EARLY_TERM_EN` defined: at the start of each BUSY cycle, the remaining multiplier register is checked. If its bits are all 0 or all 1, every remaining slice encodes 0. The block then goes to DONE without modifying acc, and that cycle is consumed. `out_valid` arrives at T+2+k, where k is the number of iterations executed. Example: op2=0 gives T+2; op2=1 gives T+3.
- Not defined: fixed 33-iteration latency, and no comparison logic is synthesised.

## Structure
- Package `booth_mul_pkg`: FSM state enum (IDLE, BUSY, DONE), `ITERS`, accumulator width 130, extended-multiplier width 67, slice encoding constants.
- One sub-module `booth_pp_gen`: combinational 3-bit slice + 130-bit multiplicand -> 130-bit partial product. The sequencer owns all registers.

## Test plan
- Unsigned 3 x 5: `result`=15. `out_valid` exactly at T+34 (macro off).
- Signed -1 x -1 (0xFFFF_FFFF_FFFF_FFFF both): `result`=1. Same operands with `op_signed`=0: `result`=0xFFFFFFFFFFFFFFFE_0000000000000001.
- Signed 0x8000_0000_0000_0000 x 2: `result`=0xFFFFFFFFFFFFFFFF_0000000000000000. Random signed/unsigned sweep against a reference model.
- Backpressure: `out_ready` low 10 cycles after DONE. `result` stable, `in_ready` low, and a new `in_valid` is ignored. Then `out_ready` high: IDLE next cycle.
- `flush` at iteration 10, and a separate `rst` pulse at iteration 20: no `out_valid`, IDLE next cycle (immediately for `rst`). A following 7 x 6 returns 42.
- Macro on: op2=0 gives `out_valid` at T+2; op2=1 at T+3; op2=0xFFFF_FFFF_FFFF_FFFF signed at T+3 with `result`=-op1.
